// File: rtl/opti_pkg.sv
// Shared constants and source state encoding for the opti filter slice.
// Filter-side blocks reuse DATA_W / ADDR_W from here.
package opti_pkg;

  localparam int MAX_SAMPLES = 2048;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = $clog2(MAX_SAMPLES);
  localparam int GAP_W       = 8;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_RUN   = 2'd1,
    SRC_DRAIN = 2'd2,
    SRC_FIN   = 2'd3
  } src_state_t;

endpackage

// File: rtl/opti_src_pacer.sv
// Interval down-counter: tick when a sample read is due.
// Ports: clear/en/load control, reload value, tick out.
module opti_src_pacer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [GAP_W-1:0] reload,
  output logic             tick
);

  logic [GAP_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/opti_sample_source.sv
// Paced sample streamer: memory reads -> data_out/valid, done at end.
// Ports: start/abort/config in, mem read port, data_out/valid, busy/done.
// Optional OPTI_SRC_LOOP_EN adds loop_mode (continuous wrap until abort).
module opti_sample_source #(
  parameter int DATA_W = opti_pkg::DATA_W,
  parameter int ADDR_W = opti_pkg::ADDR_W,
  parameter int GAP_W  = opti_pkg::GAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic [GAP_W-1:0]  interval,
`ifdef OPTI_SRC_LOOP_EN
  input  logic              loop_mode,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              done
);

  import opti_pkg::*;

  src_state_t state;
  src_state_t state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic [ADDR_W-1:0] idx;

  logic launch;
  logic tick;
  logic is_last;
  logic loop_on;

  // read issued last cycle; data arrives on mem_rdata now
  logic rd_pend;
  logic last_pend;
  // current data_out belongs to sample N-1
  logic out_last;

`ifdef OPTI_SRC_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q <= 1'b0;
    end else if (launch) begin
      loop_q <= loop_mode;
    end
  end

  assign loop_on = loop_q;
`else
  assign loop_on = 1'b0;
`endif

  assign launch  = (state == SRC_IDLE) && start && !abort;
  assign is_last = (idx == last_idx_q);
  assign mem_addr = base_q + idx;

  opti_src_pacer #(
    .GAP_W (GAP_W)
  ) u_pacer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == SRC_IDLE),
    .en     ((state == SRC_RUN) && !abort),
    .load   (tick),
    .reload (gap_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SRC_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = SRC_IDLE;
    end else begin
      unique case (state)
        SRC_IDLE: begin
          if (start) state_nx = SRC_RUN;
        end
        SRC_RUN: begin
          if (tick && is_last && !loop_on)
            state_nx = SRC_DRAIN;
        end
        SRC_DRAIN: begin
          if (data_out_valid && out_last)
            state_nx = SRC_FIN;
        end
        SRC_FIN: begin
          state_nx = SRC_IDLE;
        end
        default: state_nx = SRC_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != SRC_IDLE);
    mem_rd_en = tick;
    done      = (state == SRC_FIN) ||
                (loop_on && data_out_valid && out_last);
  end

  // run configuration; count 0 wraps to 2047 = 2048 samples,
  // interval 0 behaves as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      last_idx_q <= '0;
      gap_q      <= '0;
    end else if (launch) begin
      base_q     <= base_addr;
      last_idx_q <= sample_count - 1'b1;
      gap_q      <= (interval == '0) ? '0 : interval - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (launch) begin
      idx <= '0;
    end else if (tick) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend        <= 1'b0;
      last_pend      <= 1'b0;
      out_last       <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else if (abort) begin
      rd_pend        <= 1'b0;
      last_pend      <= 1'b0;
      out_last       <= 1'b0;
      data_out_valid <= 1'b0;
    end else begin
      rd_pend        <= tick;
      last_pend      <= tick && is_last;
      data_out_valid <= rd_pend;
      out_last       <= rd_pend && last_pend;
      if (rd_pend) data_out <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_opti_sample_source.sv
// Scoreboard bench for opti_sample_source: model pushes expected
// reads/samples/done per cycle, a negedge monitor pops and compares.
module tb_opti_sample_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] base_addr = '0;
  logic [10:0] sample_count = '0;
  logic [7:0]  interval = '0;
`ifdef OPTI_SRC_LOOP_EN
  logic        loop_mode = 1'b0;
`endif
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  opti_sample_source #(
    .DATA_W (16),
    .ADDR_W (11),
    .GAP_W  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .sample_count   (sample_count),
    .interval       (interval),
`ifdef OPTI_SRC_LOOP_EN
    .loop_mode      (loop_mode),
`endif
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .done           (done)
  );

  logic [15:0] mem [0:2047];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
  } ev_t;

  ev_t rq[$];
  ev_t vq[$];
  ev_t dq[$];

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      while (rq.size() > 0 && rq[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL read_missing: none at cyc %0d, required addr %0d",
                 rq[0].c, rq[0].v);
        void'(rq.pop_front());
      end
      while (vq.size() > 0 && vq[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL valid_missing: none at cyc %0d, required data %h",
                 vq[0].c, vq[0].v);
        void'(vq.pop_front());
      end
      while (dq.size() > 0 && dq[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing: none at cyc %0d, required pulse",
                 dq[0].c);
        void'(dq.pop_front());
      end
      if (mem_rd_en) begin
        checks++;
        if (rq.size() == 0 || rq[0].c != cyc) begin
          errors++;
          $display("FAIL read_spurious: cyc %0d addr %0d, required none",
                   cyc, mem_addr);
        end else begin
          if (rq[0].v != {5'd0, mem_addr}) begin
            errors++;
            $display("FAIL read_addr: cyc %0d got %0d, required %0d",
                     cyc, mem_addr, rq[0].v);
          end
          void'(rq.pop_front());
        end
      end
      if (data_out_valid) begin
        checks++;
        if (vq.size() == 0 || vq[0].c != cyc) begin
          errors++;
          $display("FAIL valid_spurious: cyc %0d data %h, required none",
                   cyc, data_out);
        end else begin
          if (vq[0].v != data_out) begin
            errors++;
            $display("FAIL data: cyc %0d got %h, required %h",
                     cyc, data_out, vq[0].v);
          end
          void'(vq.pop_front());
        end
      end
      if (done) begin
        checks++;
        if (dq.size() == 0 || dq[0].c != cyc) begin
          errors++;
          $display("FAIL done_spurious: cyc %0d got 1, required 0", cyc);
        end else begin
          void'(dq.pop_front());
        end
      end
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cyc %0d got %0d, required %0d", nm, cyc, act, exp);
    end
  endfunction

  // advance to cycle c, positioned just after its rising edge
  task automatic goto(input int c);
    int g = 0;
    while (cyc < c && g < 100000) begin
      @(posedge clk); #1; g++;
    end
    if (cyc != c) chk("goto_timeout", cyc, c);
  endtask

  // advance to the falling edge inside cycle c
  task automatic at_neg(input int c);
    int g = 0;
    do begin
      @(negedge clk); g++;
    end while (cyc < c && g < 100000);
    if (cyc != c) chk("wait_timeout", cyc, c);
  endtask

  // reference: read k at c0+k*p, sample at +2, done after last sample
  // (or with every sample N-1 when looping); reads before rd_lim and
  // outputs before out_lim survive a stop
  task automatic plan(input int b, input int n, input int p, input bit lp,
                      input int c0, input int rd_lim, input int out_lim);
    int k = 0;
    forever begin
      int rc = c0 + k * p;
      int ix = k % n;
      int ad = (b + ix) % 2048;
      if (rc >= rd_lim) break;
      if (!lp && k >= n) break;
      rq.push_back('{rc, 16'(ad)});
      if (rc + 2 < out_lim) vq.push_back('{rc + 2, mem[ad]});
      if (lp && ix == n - 1 && rc + 2 < out_lim)
        dq.push_back('{rc + 2, 16'd0});
      if (!lp && k == n - 1 && rc + 3 < out_lim)
        dq.push_back('{rc + 3, 16'd0});
      k++;
    end
  endtask

  task automatic run(input int b, input int n_raw, input int p_raw,
                     input bit lp, input int abort_off, input int rst_off);
    int n = (n_raw == 0) ? 2048 : n_raw;
    int p = (p_raw == 0) ? 1 : p_raw;
    int c0, a, r, d, rd_lim, out_lim;
    @(posedge clk); #1;
    c0 = cyc + 1;
    a = c0 + abort_off;
    r = c0 + rst_off;
    rd_lim = 1 << 30;
    out_lim = 1 << 30;
    if (abort_off >= 0) begin
      rd_lim = a; out_lim = a + 1;
    end else if (rst_off >= 0) begin
      rd_lim = r; out_lim = r;
    end
    plan(b, n, p, lp, c0, rd_lim, out_lim);
    start = 1'b1;
    base_addr = 11'(b);
    sample_count = 11'(n_raw);
    interval = 8'(p_raw);
`ifdef OPTI_SRC_LOOP_EN
    loop_mode = lp;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 11'($urandom);
    sample_count = 11'($urandom);
    interval = 8'($urandom);
`ifdef OPTI_SRC_LOOP_EN
    loop_mode = 1'($urandom);
`endif
    @(negedge clk);
    chk("busy_first_run_cycle", int'(busy), 1);
    if (abort_off >= 0) begin
      goto(a);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_abort", int'(busy), 0);
      chk("valid_after_abort", int'(data_out_valid), 0);
      @(negedge clk);
      chk("busy_stays_low", int'(busy), 0);
    end else if (rst_off >= 0) begin
      goto(r);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs",
          int'({mem_rd_en, mem_addr, data_out, data_out_valid, busy, done}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      d = c0 + (n - 1) * p + 3;
      at_neg(d);
      chk("done_cycle", int'(done), 1);
      chk("busy_at_done", int'(busy), 1);
      at_neg(d + 1);
      chk("busy_after_done", int'(busy), 0);
    end
    repeat (4) @(negedge clk);
    chk("queues_drained", rq.size() + vq.size() + dq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        int'({mem_rd_en, mem_addr, data_out, data_out_valid, busy, done}), 0);
    rst_n = 1'b1;

    run(0, 4, 1, 1'b0, -1, -1);
    run(int'($urandom_range(0, 2047)), 3, 5, 1'b0, -1, -1);
    run(2046, 4, int'($urandom_range(0, 3)), 1'b0, -1, -1);
    run(int'($urandom_range(0, 2047)), 0, 0, 1'b0, -1, -1);

    begin
      int p = int'($urandom_range(1, 4));
      run(int'($urandom_range(0, 2047)), 10, p, 1'b0, p + 1, -1);
    end

    // start together with abort while idle must not launch
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("start_abort_no_read", rq.size(), 0);

    run(int'($urandom_range(0, 2047)), 10, 2, 1'b0, -1, 7);
    run(int'($urandom_range(0, 2047)), 5, 1, 1'b0, -1, -1);

    for (int i = 0; i < 6; i++)
      run(int'($urandom_range(0, 2047)), int'($urandom_range(1, 20)),
          int'($urandom_range(0, 6)), 1'b0, -1, -1);

`ifdef OPTI_SRC_LOOP_EN
    run(5, 3, int'($urandom_range(1, 3)), 1'b1, 20, -1);
    run(2047, 4, 0, 1'b1, 13, -1);
    run(int'($urandom_range(0, 2047)), 6, 2, 1'b0, -1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opti_sample_source.md
Name: opti_sample_source

Overview:
- Stimulus-side streamer feeding the cascaded-SOS filter's sample input.
- Reads Q2.14 samples from a synchronous sample RAM/ROM (1-cycle read latency) and drives data_out/data_out_valid at a programmable sample interval.
- Counts samples and pulses done after the last one, so the filter input is driven by hardware rather than the bench.

Parameters:
- DATA_W, 16, sample width (Q2.14).
- ADDR_W, 11, sample memory address width; matches the filter result address width.
- GAP_W, 8, width of the interval field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start request; sampled only in IDLE.
- abort  in  1  synchronous stop; overrides all other activity.
- base_addr  in  ADDR_W  first memory address; latched at start.
- sample_count  in  ADDR_W  number of samples to send; 0 means 2048; latched at start.
- interval  in  GAP_W  cycles between sample requests; 0 is treated as 1; latched at start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory data, valid one cycle after mem_rd_en.
- data_out  out  DATA_W  sample to the filter data_in (Q2.14, passed through unmodified).
- data_out_valid  out  1  one-cycle qualifier per sample; connects to the filter's data_in_valid.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 and abort=0 latches base_addr, count N (0 maps to 2048) and interval P (0 maps to 1).
  - Next cycle: enter RUN with busy=1.
- RUN: issue read k (k=0..N-1) at cycle c0+k*P, where c0 is the first RUN cycle.
  - mem_rd_en=1 and mem_addr=(base_addr+k) mod 2048; no other mem_rd_en cycles.
  - Address wraps 2047 to 0 by natural ADDR_W truncation.
  - After read N-1 is issued, go to DRAIN.
- Output path: mem_rdata is registered into data_out.
  - data_out_valid is high in cycle c0+k*P+2, a fixed 2-cycle request-to-valid latency.
  - data_out holds its last value when not valid.
  - P=1 gives back-to-back valid samples.
- DRAIN: wait until the last in-flight sample has been emitted, then go to FIN.
- FIN: done=1 for exactly one cycle, the cycle after the last data_out_valid. busy is still 1 in that cycle, then drops to 0 and the state returns to IDLE.
- start while busy: ignored, with no effect on counters or latched values.
- abort, any state:
  - Next cycle: IDLE, busy=0, mem_rd_en=0, data_out_valid=0.
  - Any in-flight read data is discarded and no done pulse is generated.
  - abort and start in the same cycle: abort wins and no run starts.
- Reset asserted mid-run: immediate return to reset values, no done pulse.
- Pacing: an interval counter reloads to P-1 at each request and counts down to 0.
- Input stability: inputs other than start, abort and mem_rdata may change freely during a run without effect.

Optional Feature:
- Macro: OPTI_SRC_LOOP_EN.
- Defined:
  - Adds input port loop_mode (1 bit), latched at start.
  - With loop_mode=1, after read N-1 the next read returns to base_addr at normal P spacing, with no DRAIN/FIN.
  - done pulses for one cycle coincident with the data_out_valid of each sample N-1 (once per wrap).
  - busy stays high until abort.
  - With loop_mode=0, behaviour is identical to the non-macro build.
- Undefined: no loop_mode port; single pass only.

Decomposition:
- Shared package opti_pkg:
  - constants DATA_W=16, ADDR_W=11, MAX_SAMPLES=2048;
  - the source state encoding (IDLE/RUN/DRAIN/FIN).
  - The filter-side blocks reuse DATA_W/ADDR_W from the same package.
- Sub-module opti_src_pacer:
  - interval down-counter with load/enable/clear;
  - emits a one-cycle tick when a read is due.
- Sequencing FSM, index counter and output register stay in the top module.

Test Plan:
- Basic run: base_addr=0, sample_count=4, interval=1, memory[i]=16'h1000+i.
  - Required: reads at cycles c0..c0+3; valid at c0+2..c0+5 with data 1000,1001,1002,1003.
  - Required: done at c0+6 only; busy falls at c0+7.
- Paced run: interval=5, count=3.
  - Required: mem_rd_en exactly at c0, c0+5, c0+10; data_out_valid at c0+2, c0+7, c0+12; done one cycle after the last valid.
- Address wrap: base_addr=2046, count=4.
  - Required: mem_addr sequence 2046, 2047, 0, 1.
- count=0: run with sample_count=0.
  - Required: exactly 2048 valid pulses, then done; interval=0 behaves as interval=1.
- Abort: abort asserted one cycle after the 2nd read of a count=10 run.
  - Required: next cycle busy=0 and data_out_valid=0; the in-flight sample is never emitted; no done.
  - Required: start in the same cycle as abort is ignored.
- Loop build (OPTI_SRC_LOOP_EN, loop_mode=1, count=3, base 5):
  - Required: addresses 5,6,7,5,6,7…; done with each sample from address 7; abort stops the run.
- Reset mid-run: rst_n low for 1 cycle mid-run.
  - Required: all outputs 0 asynchronously; the block then accepts a new start.
